// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared IEEE-754 single-precision constants, FSM states and packing helper
package fp_pkg;

  localparam int FP_BIAS  = 127;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ABS  = 2'd1,
    S_NORM = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  // Assemble a single-precision word from its fields
  function automatic logic [31:0] fp_pack(input logic                sign,
                                          input logic [FP_EXP_W-1:0] exp,
                                          input logic [FP_MAN_W-1:0] man);
    return {sign, exp, man};
  endfunction

endpackage

// File: rtl/cordic_fix2float.sv
// rtl/cordic_fix2float.sv - converts the signed fixed-point CORDIC result to IEEE-754 single
module cordic_fix2float #(
  parameter int IN_W   = 22,
  parameter int FRAC_W = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_data,
  output logic            busy,
  output logic            out_valid,
  output logic [31:0]     out_data
);

  import fp_pkg::*;

  localparam int SH_W = $clog2(IN_W);
  // Exponent of a value whose leading one already sits in the top bit
  localparam logic [FP_EXP_W-1:0] EXP_OFF = FP_EXP_W'(FP_BIAS + IN_W - 1 - FRAC_W);

  state_t                state, state_n;
  logic                  in_valid_d;
  logic                  accept;
  logic                  norm_done;
  logic                  sign;
  logic [IN_W-1:0]       raw;
  logic [IN_W-1:0]       mag;
  logic [SH_W-1:0]       shifts;
  logic [FP_EXP_W-1:0]   exp_w;
  logic [FP_MAN_W-1:0]   man_w;
  logic [31:0]           pack_w;

  // Next-state decode, rising-edge accept and result packing
  always_comb begin
    state_n   = state;
    accept    = in_valid & ~in_valid_d & (state == S_IDLE);
    norm_done = (mag == '0) | mag[IN_W-1];
    exp_w     = EXP_OFF - FP_EXP_W'(shifts);
    // Drop the hidden bit and left-align the remaining magnitude bits
    man_w     = FP_MAN_W'(mag[IN_W-2:0]) << (24 - IN_W);
    // Zero always packs as +0 regardless of the captured sign
    pack_w    = (mag == '0) ? 32'h0000_0000 : fp_pack(sign, exp_w, man_w);
    case (state)
      S_IDLE: if (accept) state_n = S_ABS;
      S_ABS:  state_n = S_NORM;
      S_NORM: if (norm_done) state_n = S_OUT;
      S_OUT:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State register with registered status outputs derived from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      in_valid_d <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_n;
      in_valid_d <= in_valid;
      busy       <= (state_n != S_IDLE);
      out_valid  <= (state_n == S_OUT);
    end
  end

  // Capture, absolute value, one-bit-per-cycle normalise and result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign     <= 1'b0;
      raw      <= '0;
      mag      <= '0;
      shifts   <= '0;
      out_data <= 32'h0000_0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            sign <= in_data[IN_W-1];
            raw  <= in_data;
          end
        end
        S_ABS: begin
          mag    <= sign ? -raw : raw;
          shifts <= '0;
        end
        S_NORM: begin
          if (norm_done) begin
            out_data <= pack_w;
          end else begin
            mag    <= mag << 1;
            shifts <= shifts + SH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_fix2float.sv
// tb/tb_cordic_fix2float.sv - table and scoreboard bench for cordic_fix2float
module tb_cordic_fix2float;

  localparam int IN_W   = 22;
  localparam int FRAC_W = 20;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [IN_W-1:0] in_data;
  logic            busy;
  logic            out_valid;
  logic [31:0]     out_data;

  always #5 clk = ~clk;

  cordic_fix2float #(.IN_W(IN_W), .FRAC_W(FRAC_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  typedef struct {
    logic [IN_W-1:0] din;
    logic [31:0]     dout;
    int              lat;
  } vec_t;

  vec_t        tbl [9];
  logic [31:0] sbq [$];
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: locate the leading one of the magnitude and build the fields directly
  function automatic logic [31:0] model(input logic [IN_W-1:0] d, output int k);
    logic signed [IN_W-1:0] sd;
    longint v, m;
    int p;
    logic [7:0]  e;
    logic [22:0] man;
    sd = d;
    v  = longint'(sd);
    m  = (v < 0) ? -v : v;
    k  = 0;
    if (m == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < IN_W; i++) if (((m >> i) & 1) != 0) p = i;
    k   = IN_W - 1 - p;
    e   = 8'(127 + p - FRAC_W);
    man = 23'((m << (23 - p)) & 64'h7F_FFFF);
    return {(v < 0), e, man};
  endfunction

  // Scoreboard: every output pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1) begin
      pulses++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got out_data %h expected no pulse", out_data);
      end else begin
        chk("out_data", out_data, sbq.pop_front());
      end
    end
  end

  task automatic convert(input logic [IN_W-1:0] d, input logic [31:0] e, input int lat,
                         input string name);
    int n;
    bit seen;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    chk({name, "_busy"}, 32'(busy), 32'd1);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk({name, "_latency"}, 32'(n), 32'(lat));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int k;
    int p0;
    logic [IN_W-1:0] d;
    logic [31:0] e;

    tbl[0] = '{22'h100000, 32'h3F80_0000, 3};
    tbl[1] = '{22'h300000, 32'hBF80_0000, 3};
    tbl[2] = '{22'h200000, 32'hC000_0000, 2};
    tbl[3] = '{22'h080000, 32'h3F00_0000, 4};
    tbl[4] = '{22'h09B74E, 32'h3F1B_74E0, 4};
    tbl[5] = '{22'h000001, 32'h3580_0000, 23};
    tbl[6] = '{22'h000000, 32'h0000_0000, 2};
    tbl[7] = '{22'h1FFFFF, 32'h3FFF_FFF8, 3};
    tbl[8] = '{22'h3FFFFF, 32'hB580_0000, 23};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'h0);
    reset = 1'b0;

    // Back-to-back table vectors also exercise accept in the cycle after OUT
    for (int i = 0; i < 9; i++) convert(tbl[i].din, tbl[i].dout, tbl[i].lat, $sformatf("tbl%0d", i));

    for (int i = 0; i < 8; i++) begin
      d = IN_W'($urandom);
      e = model(d, k);
      convert(d, e, 2 + k, $sformatf("rand%0d", i));
    end

    // Level held high across the span of two conversions gives one result
    @(negedge clk);
    in_data  = 22'h080000;
    in_valid = 1'b1;
    sbq.push_back(32'h3F00_0000);
    p0 = pulses;
    repeat (60) @(negedge clk);
    chk("hold_high_pulses", 32'(pulses - p0), 32'd1);
    in_valid = 1'b0;

    // A second rising edge while busy is dropped
    @(negedge clk);
    in_data  = 22'h000001;
    in_valid = 1'b1;
    sbq.push_back(32'h3580_0000);
    p0 = pulses;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    in_data  = 22'h100000;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("busy_edge_pulses", 32'(pulses - p0), 32'd1);
    chk("out_data_hold", out_data, 32'h3580_0000);
    chk("idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-normalise, then a level still high counts as a new edge
    @(negedge clk);
    in_data  = 22'h000001;
    in_valid = 1'b1;
    sbq.push_back(32'h3580_0000);
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_out_data", out_data, 32'h0);
    sbq.delete();
    in_data = 22'h300000;
    @(negedge clk);
    @(negedge clk);
    p0 = pulses;
    sbq.push_back(32'hBF80_0000);
    reset = 1'b0;
    for (int n = 0; n < 40 && pulses == p0; n++) @(negedge clk);
    chk("post_reset_pulses", 32'(pulses - p0), 32'd1);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_reset_pulses_final", 32'(pulses - p0), 32'd1);

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
